// File: rtl/raifes_hasti_sram_dp_cfg.sv
// -----------------------------------------------------------------------------
// raifes_hasti_sram_dp_cfg
//
// Dual-port AHB-Lite (HASTI) SRAM model. Port p0 (data) and port p1
// (instruction) are independent slaves over a single shared word array.
//
// Parameters
//   NWORDS       array depth in 32-bit words (power of two, >= 16)
//   WAIT_STATES  hready-low cycles inserted per data phase (0..7)
//   P1_WRITE_EN  1: p1 may write, 0: p1 writes get an ERROR response
//
// Ports (N = 0, 1)
//   hclk, hreset        clock, asynchronous active-high reset
//   pN_haddr/hwrite/hsize/htrans/hwdata   AHB-Lite address and write data
//   pN_hburst/hmastlock/hprot             accepted, unused
//   pN_hrdata           read data, non-zero only in a read's DATA cycle
//   pN_hready           transfer done / address phase accepted
//   pN_hresp            0 = OKAY, 1 = ERROR (two-cycle response)
//
// Each port runs its own IDLE/WAIT/DATA/ERR1/ERR2 state machine. Writes land
// in the array at the edge ending DATA. A read in DATA returns the array word
// with any bytes the other port is writing to that same word in that same
// cycle merged in. On a same-word, same-edge double write, p0 owns the
// overlapping bytes.
// -----------------------------------------------------------------------------
module raifes_hasti_sram_dp_cfg #(
    parameter int NWORDS      = 65536,
    parameter int WAIT_STATES = 0,
    parameter int P1_WRITE_EN = 0
) (
    input  logic        hclk,
    input  logic        hreset,

    input  logic [31:0] p0_haddr,
    input  logic        p0_hwrite,
    input  logic [2:0]  p0_hsize,
    input  logic [2:0]  p0_hburst,
    input  logic        p0_hmastlock,
    input  logic [3:0]  p0_hprot,
    input  logic [1:0]  p0_htrans,
    input  logic [31:0] p0_hwdata,
    output logic [31:0] p0_hrdata,
    output logic        p0_hready,
    output logic        p0_hresp,

    input  logic [31:0] p1_haddr,
    input  logic        p1_hwrite,
    input  logic [2:0]  p1_hsize,
    input  logic [2:0]  p1_hburst,
    input  logic        p1_hmastlock,
    input  logic [3:0]  p1_hprot,
    input  logic [1:0]  p1_htrans,
    input  logic [31:0] p1_hwdata,
    output logic [31:0] p1_hrdata,
    output logic        p1_hready,
    output logic        p1_hresp
);

    localparam int AW = $clog2(NWORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Port signals gathered into arrays so both ports share one generate body.
    logic [31:0]   haddr   [2];
    logic          hwrite  [2];
    logic [2:0]    hsize   [2];
    logic [1:0]    htrans  [2];
    logic [31:0]   hwdata  [2];
    logic [31:0]   hrdata  [2];
    logic          hready  [2];
    logic          hresp   [2];

    // Write side of each port, seen by the array and by the other port's
    // read-forwarding path.
    logic          wr_en   [2];
    logic [AW-1:0] wr_idx  [2];
    logic [3:0]    wr_mask [2];

    logic [31:0]   mem [NWORDS];

    assign haddr[0]  = p0_haddr;
    assign hwrite[0] = p0_hwrite;
    assign hsize[0]  = p0_hsize;
    assign htrans[0] = p0_htrans;
    assign hwdata[0] = p0_hwdata;
    assign haddr[1]  = p1_haddr;
    assign hwrite[1] = p1_hwrite;
    assign hsize[1]  = p1_hsize;
    assign htrans[1] = p1_htrans;
    assign hwdata[1] = p1_hwdata;

    assign p0_hrdata = hrdata[0];
    assign p0_hready = hready[0];
    assign p0_hresp  = hresp[0];
    assign p1_hrdata = hrdata[1];
    assign p1_hready = hready[1];
    assign p1_hresp  = hresp[1];

    // Burst, lock and protection attributes have no effect on a flat memory.
    logic unused_attr;
    assign unused_attr = ^{p0_hburst, p0_hmastlock, p0_hprot,
                           p1_hburst, p1_hmastlock, p1_hprot};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam int OTHER = 1 - gi;
            localparam bit WR_OK = (gi == 0) || (P1_WRITE_EN != 0);

            state_t        state_reg, state_next;
            logic [2:0]    wait_cnt_reg, wait_cnt_next;
            logic [AW-1:0] idx_reg;
            logic [1:0]    lsb_reg;
            logic [1:0]    size_reg;
            logic          write_reg;
            logic          accept;
            logic          legal;
            logic [3:0]    mask_base;
            logic [31:0]   rd_word;

            // NONSEQ (2'b10) and SEQ (2'b11) both have htrans[1] set.
            assign accept = hready[gi] && htrans[gi][1];

            always_comb begin
                legal = 1'b1;
                if (hsize[gi] > 3'd2)
                    legal = 1'b0;
                if ((hsize[gi] == 3'd1) && haddr[gi][0])
                    legal = 1'b0;
                if ((hsize[gi] == 3'd2) && (haddr[gi][1:0] != 2'b00))
                    legal = 1'b0;
                if ({2'b00, haddr[gi][31:2]} >= 32'(NWORDS))
                    legal = 1'b0;
                if (!WR_OK && hwrite[gi])
                    legal = 1'b0;
            end

            always_comb begin
                state_next    = state_reg;
                wait_cnt_next = wait_cnt_reg;
                case (state_reg)
                    ST_WAIT: begin
                        if (int'(wait_cnt_reg) >= WAIT_STATES - 1)
                            state_next = ST_DATA;
                        else
                            wait_cnt_next = wait_cnt_reg + 3'd1;
                    end
                    ST_ERR1: state_next = ST_ERR2;
                    default: begin
                        // IDLE, DATA and ERR2 all present hready=1, so each
                        // doubles as the address phase of the next transfer.
                        state_next = ST_IDLE;
                        if (accept) begin
                            if (!legal) begin
                                state_next = ST_ERR1;
                            end else if (WAIT_STATES > 0) begin
                                state_next    = ST_WAIT;
                                wait_cnt_next = 3'd0;
                            end else begin
                                state_next = ST_DATA;
                            end
                        end
                    end
                endcase
            end

            always_ff @(posedge hclk or posedge hreset) begin
                if (hreset) begin
                    state_reg    <= ST_IDLE;
                    wait_cnt_reg <= 3'd0;
                    idx_reg      <= '0;
                    lsb_reg      <= 2'd0;
                    size_reg     <= 2'd0;
                    write_reg    <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    wait_cnt_reg <= wait_cnt_next;
                    if (accept) begin
                        idx_reg   <= haddr[gi][AW+1:2];
                        lsb_reg   <= haddr[gi][1:0];
                        size_reg  <= hsize[gi][1:0];
                        write_reg <= hwrite[gi];
                    end
                end
            end

            always_comb begin
                case (size_reg)
                    2'd0:    mask_base = 4'b0001;
                    2'd1:    mask_base = 4'b0011;
                    default: mask_base = 4'b1111;
                endcase
            end

            assign wr_en[gi]   = (state_reg == ST_DATA) && write_reg;
            assign wr_idx[gi]  = idx_reg;
            assign wr_mask[gi] = mask_base << lsb_reg;

            // Bytes the other port writes to this word in this very cycle are
            // returned as new data; the array itself updates only at the edge.
            always_comb begin
                rd_word = mem[idx_reg];
                for (int b = 0; b < 4; b++) begin
                    if (wr_en[OTHER] && (wr_idx[OTHER] == idx_reg) && wr_mask[OTHER][b])
                        rd_word[8*b +: 8] = hwdata[OTHER][8*b +: 8];
                end
            end

            assign hrdata[gi] = ((state_reg == ST_DATA) && !write_reg) ? rd_word : 32'd0;
            assign hready[gi] = (state_reg != ST_WAIT) && (state_reg != ST_ERR1);
            assign hresp[gi]  = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
        end
    endgenerate

    // p1 is applied first so that p0's later non-blocking write takes the
    // overlapping bytes of a same-word collision. The reset guard covers a
    // reset edge that coincides with a clock edge.
    always_ff @(posedge hclk) begin
        if (!hreset) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_en[1] && wr_mask[1][b])
                    mem[wr_idx[1]][8*b +: 8] <= hwdata[1][8*b +: 8];
                if (wr_en[0] && wr_mask[0][b])
                    mem[wr_idx[0]][8*b +: 8] <= hwdata[0][8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_raifes_hasti_sram_dp_cfg.sv
// -----------------------------------------------------------------------------
// Bench for raifes_hasti_sram_dp_cfg. Two instances share one clock:
//   dut index 0: WAIT_STATES=0, P1_WRITE_EN=1
//   dut index 1: WAIT_STATES=2, P1_WRITE_EN=0
// Both use NWORDS=256. The reference model is a byte-addressed memory with
// the legality and forwarding rules applied directly to byte lanes.
// -----------------------------------------------------------------------------
module tb_raifes_hasti_sram_dp_cfg;

    localparam int NW = 256;

    logic clk;
    logic rst [2];

    logic [31:0] haddr  [2][2];
    logic        hwrite [2][2];
    logic [2:0]  hsize  [2][2];
    logic [1:0]  htrans [2][2];
    logic [31:0] hwdata [2][2];
    logic [31:0] hrdata [2][2];
    logic        hready [2][2];
    logic        hresp  [2][2];

    logic [2:0] tie_burst = 3'd0;
    logic       tie_lock  = 1'b0;
    logic [3:0] tie_prot  = 4'h3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mb [2][4*NW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    raifes_hasti_sram_dp_cfg #(.NWORDS(NW), .WAIT_STATES(0), .P1_WRITE_EN(1)) dut0 (
        .hclk(clk), .hreset(rst[0]),
        .p0_haddr(haddr[0][0]), .p0_hwrite(hwrite[0][0]), .p0_hsize(hsize[0][0]),
        .p0_hburst(tie_burst), .p0_hmastlock(tie_lock), .p0_hprot(tie_prot),
        .p0_htrans(htrans[0][0]), .p0_hwdata(hwdata[0][0]), .p0_hrdata(hrdata[0][0]),
        .p0_hready(hready[0][0]), .p0_hresp(hresp[0][0]),
        .p1_haddr(haddr[0][1]), .p1_hwrite(hwrite[0][1]), .p1_hsize(hsize[0][1]),
        .p1_hburst(tie_burst), .p1_hmastlock(tie_lock), .p1_hprot(tie_prot),
        .p1_htrans(htrans[0][1]), .p1_hwdata(hwdata[0][1]), .p1_hrdata(hrdata[0][1]),
        .p1_hready(hready[0][1]), .p1_hresp(hresp[0][1])
    );

    raifes_hasti_sram_dp_cfg #(.NWORDS(NW), .WAIT_STATES(2), .P1_WRITE_EN(0)) dut1 (
        .hclk(clk), .hreset(rst[1]),
        .p0_haddr(haddr[1][0]), .p0_hwrite(hwrite[1][0]), .p0_hsize(hsize[1][0]),
        .p0_hburst(tie_burst), .p0_hmastlock(tie_lock), .p0_hprot(tie_prot),
        .p0_htrans(htrans[1][0]), .p0_hwdata(hwdata[1][0]), .p0_hrdata(hrdata[1][0]),
        .p0_hready(hready[1][0]), .p0_hresp(hresp[1][0]),
        .p1_haddr(haddr[1][1]), .p1_hwrite(hwrite[1][1]), .p1_hsize(hsize[1][1]),
        .p1_hburst(tie_burst), .p1_hmastlock(tie_lock), .p1_hprot(tie_prot),
        .p1_htrans(htrans[1][1]), .p1_hwdata(hwdata[1][1]), .p1_hrdata(hrdata[1][1]),
        .p1_hready(hready[1][1]), .p1_hresp(hresp[1][1])
    );

    // ---------------- checking helpers and reference model ----------------
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    function automatic int ws_of(int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit is_legal(int d, int p, logic [31:0] a, logic w, logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((int'(a[1:0]) % (1 << sz)) != 0) return 1'b0;
        if (a >= 32'(4*NW)) return 1'b0;
        if ((p == 1) && w && (d == 1)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mword(int d, logic [31:0] a);
        int base;
        base = int'(a) & ~3;
        return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
    endfunction

    function automatic void mwrite(int d, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            int ba;
            ba = int'(a) + i;
            mb[d][ba] = wd[8*(ba%4) +: 8];
        end
    endfunction

    // Bytes written by another port to the same word replace the read bytes.
    function automatic logic [31:0] overlay(logic [31:0] base, logic [31:0] ar,
                                            logic [31:0] aw, logic [2:0] sz, logic [31:0] wd);
        logic [31:0] r;
        r = base;
        if (ar[31:2] == aw[31:2]) begin
            for (int i = 0; i < (1 << sz); i++) begin
                int lane;
                lane = (int'(aw[1:0]) + i) % 4;
                r[8*lane +: 8] = wd[8*lane +: 8];
            end
        end
        return r;
    endfunction

    // One complete non-pipelined transfer; waits counts hready-low cycles.
    task automatic xfer(input int d, input int p, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic resp, output int waits);
        waits = 0;
        rd    = 32'd0;
        resp  = 1'b0;
        @(posedge clk); #1;
        haddr[d][p]  = a;
        hwrite[d][p] = w;
        hsize[d][p]  = sz;
        htrans[d][p] = 2'b10;
        @(posedge clk); #1;
        htrans[d][p] = 2'b00;
        hwdata[d][p] = wd;
        forever begin
            @(negedge clk);
            if (hready[d][p]) begin
                rd   = hrdata[d][p];
                resp = hresp[d][p];
                break;
            end
            waits++;
            if (waits > 16) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL xfer_timeout: d%0d p%0d hready stuck low, expected high", d, p);
                break;
            end
        end
        $display("[TB] d%0d p%0d %s a=%08h sz=%0d wd=%08h rd=%08h resp=%0d waits=%0d",
                 d, p, w ? "WR" : "RD", a, sz, wd, rd, resp, waits);
    endtask

    // Single transfer checked against the model, model updated afterwards.
    task automatic op(input int d, input int p, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] rd, exp;
        logic        resp;
        int          wt;
        bit          ok;
        ok  = is_legal(d, p, a, w, sz);
        exp = ok ? mword(d, a) : 32'd0;
        xfer(d, p, a, w, sz, wd, rd, resp, wt);
        chk("op_resp", {31'd0, resp}, {31'd0, !ok});
        chk("op_waits", wt, ok ? ws_of(d) : 1);
        if (ok && !w) chk("op_rdata", rd, exp);
        if (ok && w) mwrite(d, a, sz, wd);
    endtask

    // ---------------- directed vector table (dut 0) ----------------
    typedef struct {
        int          p;
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_resp;
        int          exp_waits;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd0, rd1, e0, e1, a0, a1, d0, d1;
        logic        rs, rs0, rs1, w0, w1;
        logic [2:0]  s0, s1;
        int          wt, t0, t1, lows, nd;
        logic [31:0] got [2];
        bit          ok0, ok1;

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                haddr[d][p]  = 32'd0;
                hwrite[d][p] = 1'b0;
                hsize[d][p]  = 3'd0;
                htrans[d][p] = 2'b00;
                hwdata[d][p] = 32'd0;
            end
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk("reset_hready", {31'd0, hready[d][p]}, 32'd1);
                chk("reset_hresp",  {31'd0, hresp[d][p]},  32'd0);
                chk("reset_hrdata", hrdata[d][p], 32'd0);
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        //            p  addr           w     sz    wdata          chk   exp_rd         resp  waits
        tbl[0]  = '{0, 32'h10,       1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 0};
        tbl[1]  = '{0, 32'h10,       1'b0, 3'd2, 32'h0,        1'b1, 32'hDEADBEEF,  1'b0, 0};
        tbl[2]  = '{0, 32'h10,       1'b1, 3'd2, 32'h11223344, 1'b0, 32'h0,         1'b0, 0};
        tbl[3]  = '{0, 32'h13,       1'b1, 3'd0, 32'hAA000000, 1'b0, 32'h0,         1'b0, 0};
        tbl[4]  = '{0, 32'h10,       1'b0, 3'd2, 32'h0,        1'b1, 32'hAA223344,  1'b0, 0};
        tbl[5]  = '{0, 32'h12,       1'b1, 3'd1, 32'h55660000, 1'b0, 32'h0,         1'b0, 0};
        tbl[6]  = '{0, 32'h10,       1'b0, 3'd2, 32'h0,        1'b1, 32'h55663344,  1'b0, 0};
        tbl[7]  = '{0, 32'h2,        1'b0, 3'd2, 32'h0,        1'b0, 32'h0,         1'b1, 1};
        tbl[8]  = '{0, 32'h400,      1'b0, 3'd2, 32'h0,        1'b0, 32'h0,         1'b1, 1};
        tbl[9]  = '{0, 32'h10,       1'b1, 3'd3, 32'h0,        1'b0, 32'h0,         1'b1, 1};
        tbl[10] = '{0, 32'h11,       1'b1, 3'd1, 32'hFFFFFFFF, 1'b0, 32'h0,         1'b1, 1};
        tbl[11] = '{0, 32'h80000010, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 32'h0,         1'b1, 1};
        tbl[12] = '{1, 32'h20,       1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0,         1'b0, 0};
        tbl[13] = '{1, 32'h20,       1'b0, 3'd2, 32'h0,        1'b1, 32'hCAFEF00D,  1'b0, 0};
        tbl[14] = '{1, 32'h10,       1'b0, 3'd2, 32'h0,        1'b1, 32'h55663344,  1'b0, 0};
        tbl[15] = '{0, 32'h12,       1'b0, 3'd1, 32'h0,        1'b1, 32'h55663344,  1'b0, 0};
        tbl[16] = '{1, 32'h21,       1'b1, 3'd0, 32'h00007700, 1'b0, 32'h0,         1'b0, 0};
        tbl[17] = '{0, 32'h20,       1'b0, 3'd2, 32'h0,        1'b1, 32'hCAFE770D,  1'b0, 0};

        for (int i = 0; i < 18; i++) begin
            xfer(0, tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].wd, rd, rs, wt);
            chk("tbl_resp", {31'd0, rs}, {31'd0, tbl[i].exp_resp});
            chk("tbl_waits", wt, tbl[i].exp_waits);
            if (tbl[i].chk_rd) chk("tbl_rdata", rd, tbl[i].exp_rd);
        end

        // ---- wait states and NONSEQ+SEQ pipelining (dut 1) ----
        xfer(1, 0, 32'h8, 1'b1, 3'd2, 32'h12345678, rd, rs, wt);
        chk("ws_write_waits", wt, 2);
        xfer(1, 0, 32'hC, 1'b1, 3'd2, 32'h9ABCDEF0, rd, rs, wt);
        xfer(1, 0, 32'h8, 1'b0, 3'd2, 32'h0, rd, rs, wt);
        chk("ws_read_waits", wt, 2);
        chk("ws_read_data", rd, 32'h12345678);

        @(posedge clk); #1;
        haddr[1][0] = 32'h8; hwrite[1][0] = 1'b0; hsize[1][0] = 3'd2; htrans[1][0] = 2'b10;
        @(posedge clk); #1;
        haddr[1][0] = 32'hC; htrans[1][0] = 2'b11;
        lows = 0;
        nd   = 0;
        got[0] = 32'd0;
        got[1] = 32'd0;
        for (int c = 0; c < 20 && nd < 2; c++) begin
            @(negedge clk);
            if (!hready[1][0]) begin
                lows++;
            end else begin
                got[nd] = hrdata[1][0];
                nd++;
                @(posedge clk); #1;
                htrans[1][0] = 2'b00;
            end
        end
        $display("[TB] d1 p0 pipelined RD 0x8/0xC lows=%0d rd0=%08h rd1=%08h", lows, got[0], got[1]);
        chk("pipe_done", nd, 2);
        chk("pipe_low_cycles", lows, 4);
        chk("pipe_rd0", got[0], 32'h12345678);
        chk("pipe_rd1", got[1], 32'h9ABCDEF0);

        // p1 write with writes disabled: ERROR, array untouched
        xfer(1, 1, 32'h8, 1'b1, 3'd2, 32'hFFFFFFFF, rd, rs, wt);
        chk("p1wr_resp", {31'd0, rs}, 32'd1);
        chk("p1wr_waits", wt, 1);
        xfer(1, 1, 32'h8, 1'b0, 3'd2, 32'h0, rd, rs, wt);
        chk("p1wr_unchanged", rd, 32'h12345678);

        // ---- reset in the WAIT of a write (dut 1) ----
        xfer(1, 0, 32'h30, 1'b1, 3'd2, 32'h0BADF00D, rd, rs, wt);
        @(posedge clk); #1;
        haddr[1][0] = 32'h30; hwrite[1][0] = 1'b1; hsize[1][0] = 3'd2; htrans[1][0] = 2'b10;
        @(posedge clk); #1;
        htrans[1][0] = 2'b00;
        hwdata[1][0] = 32'hFFFFFFFF;
        chk("rst_pre_hready", {31'd0, hready[1][0]}, 32'd0);
        #2;
        rst[1] = 1'b1;
        #1;
        chk("rst_hready", {31'd0, hready[1][0]}, 32'd1);
        chk("rst_hresp",  {31'd0, hresp[1][0]},  32'd0);
        chk("rst_hrdata", hrdata[1][0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        $display("[TB] d1 reset pulsed during write WAIT at 0x30");
        xfer(1, 0, 32'h30, 1'b0, 3'd2, 32'h0, rd, rs, wt);
        chk("rst_word_kept", rd, 32'h0BADF00D);

        // ---- model prefill of bytes 0x00..0x7F on both instances ----
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 32; k++)
                op(d, 0, 32'(k*4), 1'b1, 3'd2, $urandom);

        // ---- forwarding: p0 writes word 0x40 while p1 reads it ----
        op(0, 0, 32'h40, 1'b1, 3'd2, 32'h12345678);
        fork
            xfer(0, 0, 32'h40, 1'b1, 3'd2, 32'h0000FFFF, rd0, rs0, t0);
            xfer(0, 1, 32'h40, 1'b0, 3'd2, 32'h0, rd1, rs1, t1);
        join
        chk("fwd_word", rd1, 32'h0000FFFF);
        mwrite(0, 32'h40, 3'd2, 32'h0000FFFF);
        fork
            xfer(0, 1, 32'h41, 1'b1, 3'd0, 32'h0000AB00, rd1, rs1, t1);
            xfer(0, 0, 32'h40, 1'b0, 3'd2, 32'h0, rd0, rs0, t0);
        join
        chk("fwd_byte", rd0, 32'h0000ABFF);
        mwrite(0, 32'h41, 3'd0, 32'h0000AB00);

        // ---- collision: same word, same edge, p0 owns overlapping bytes ----
        fork
            xfer(0, 0, 32'h40, 1'b1, 3'd1, 32'h00001111, rd0, rs0, t0);
            xfer(0, 1, 32'h40, 1'b1, 3'd2, 32'h22222222, rd1, rs1, t1);
        join
        mwrite(0, 32'h40, 3'd2, 32'h22222222);
        mwrite(0, 32'h40, 3'd1, 32'h00001111);
        xfer(0, 1, 32'h40, 1'b0, 3'd2, 32'h0, rd, rs, wt);
        chk("collide_word", rd, 32'h22221111);

        // ---- random single-port transfers against the model ----
        for (int k = 0; k < 150; k++) begin
            int          d, p;
            logic [31:0] a;
            d = $urandom_range(0, 1);
            p = $urandom_range(0, 1);
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) a = 32'h400 + $urandom_range(0, 4095);
            op(d, p, a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom);
        end

        // ---- random simultaneous transfers on both ports of dut 0 ----
        for (int k = 0; k < 60; k++) begin
            s0 = 3'($urandom_range(0, 2));
            s1 = 3'($urandom_range(0, 2));
            a0 = 32'($urandom_range(0, 31)) & ~((32'd1 << s0) - 32'd1);
            a1 = 32'($urandom_range(0, 31)) & ~((32'd1 << s1) - 32'd1);
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            d0 = $urandom;
            d1 = $urandom;
            ok0 = is_legal(0, 0, a0, w0, s0);
            ok1 = is_legal(0, 1, a1, w1, s1);
            e0 = mword(0, a0);
            e1 = mword(0, a1);
            if (ok1 && w1) e0 = overlay(e0, a0, a1, s1, d1);
            if (ok0 && w0) e1 = overlay(e1, a1, a0, s0, d0);
            fork
                xfer(0, 0, a0, w0, s0, d0, rd0, rs0, t0);
                xfer(0, 1, a1, w1, s1, d1, rd1, rs1, t1);
            join
            chk("dual_resp0", {31'd0, rs0}, {31'd0, !ok0});
            chk("dual_resp1", {31'd0, rs1}, {31'd0, !ok1});
            if (ok0 && !w0) chk("dual_rdata0", rd0, e0);
            if (ok1 && !w1) chk("dual_rdata1", rd1, e1);
            if (ok1 && w1) mwrite(0, a1, s1, d1);
            if (ok0 && w0) mwrite(0, a0, s0, d0);
        end

        // final readback of the shared region
        for (int k = 0; k < 8; k++)
            op(0, 0, 32'(k*4), 1'b0, 3'd2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
